// File: rtl/key_repeat_ctrl.sv
// key_repeat_ctrl: board pushbutton conditioner for the time-of-day setting logic.
// Each key goes through a 2-flop synchroniser, a counter debouncer, a press
// one-shot and a hold-to-auto-repeat state machine, giving clean one-cycle steps.
// Optional build macro KEY_REPEAT_ACCEL_EN: after the 8th auto-repeat pulse of a
// single hold the repeat period halves. Without it the period is fixed.

module key_repeat_ctrl #(
    parameter int                  NUM_KEYS             = 4,
    parameter int                  DEBOUNCE_CYCLES      = 500000,
    parameter int                  REPEAT_DELAY_CYCLES  = 25000000,
    parameter int                  REPEAT_PERIOD_CYCLES = 5000000,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK          = {NUM_KEYS{1'b1}}
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_pulse
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int REP_W   = $clog2(REP_MAX) + 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD_CYCLES - 1);
`ifdef KEY_REPEAT_ACCEL_EN
    localparam logic [REP_W-1:0] PERIOD_FAST_LAST = REP_W'((REPEAT_PERIOD_CYCLES / 2) - 1);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } stateT;

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;

    // Two-stage synchroniser; flops idle at 1 so a reset looks like "released"
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic             w_pressed;
        logic [DB_W-1:0]  r_dbCnt;
        logic             r_level;
        logic             w_levelNext;
        logic             w_rise;
        stateT            r_state;
        stateT            w_stateNext;
        logic [REP_W-1:0] r_repCnt;
        logic [REP_W-1:0] w_repCntNext;
        logic [REP_W-1:0] w_periodLast;
        logic             r_pulse;
        logic             w_pulseNext;

        assign w_pressed = ~r_sync2[i];

        // Debouncer: level follows the synchronised input only after it has disagreed for the full window
        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                r_dbCnt <= '0;
                r_level <= 1'b0;
            end else if (w_pressed != r_level) begin
                if (r_dbCnt == DB_LAST) begin
                    r_level <= w_pressed;
                    r_dbCnt <= '0;
                end else begin
                    r_dbCnt <= r_dbCnt + DB_W'(1);
                end
            end else begin
                r_dbCnt <= '0;
            end
        end

        // The FSM looks at the level being written this cycle, so the press pulse lines up
        // with the first cycle key_level reads 1 and a release suppresses a coincident repeat
        assign w_levelNext = ((w_pressed != r_level) && (r_dbCnt == DB_LAST)) ? w_pressed : r_level;
        assign w_rise      = w_levelNext & ~r_level;

`ifdef KEY_REPEAT_ACCEL_EN
        logic [2:0] r_accCnt;
        logic [2:0] w_accCntNext;

        // Count pulses issued from REPEAT, saturating; clears whenever the key goes idle
        always_comb begin
            w_accCntNext = r_accCnt;
            if (w_stateNext == IDLE) begin
                w_accCntNext = 3'd0;
            end else if ((r_state == REPEAT) && w_pulseNext && (r_accCnt != 3'd7)) begin
                w_accCntNext = r_accCnt + 3'd1;
            end
        end

        // Accelerator counter register
        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                r_accCnt <= 3'd0;
            end else begin
                r_accCnt <= w_accCntNext;
            end
        end

        // Delay pulse plus seven REPEAT pulses makes eight; after that run at half period
        assign w_periodLast = (r_accCnt == 3'd7) ? PERIOD_FAST_LAST : PERIOD_LAST;
`else
        assign w_periodLast = PERIOD_LAST;
`endif

        // Repeat FSM next-state, counter and pulse decode
        always_comb begin
            w_stateNext  = r_state;
            w_repCntNext = r_repCnt;
            w_pulseNext  = 1'b0;
            if (!w_levelNext) begin
                w_stateNext  = IDLE;
                w_repCntNext = '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            w_pulseNext  = 1'b1;
                            w_stateNext  = DELAY;
                            w_repCntNext = '0;
                        end
                    end
                    DELAY: begin
                        if (r_repCnt == DELAY_LAST) begin
                            if (REPEAT_MASK[i]) begin
                                w_pulseNext  = 1'b1;
                                w_stateNext  = REPEAT;
                                w_repCntNext = '0;
                            end
                        end else begin
                            w_repCntNext = r_repCnt + REP_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (r_repCnt == w_periodLast) begin
                            w_pulseNext  = 1'b1;
                            w_repCntNext = '0;
                        end else begin
                            w_repCntNext = r_repCnt + REP_W'(1);
                        end
                    end
                    default: begin
                        w_stateNext  = IDLE;
                        w_repCntNext = '0;
                    end
                endcase
            end
        end

        // Repeat FSM state, counter and registered pulse
        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                r_state  <= IDLE;
                r_repCnt <= '0;
                r_pulse  <= 1'b0;
            end else begin
                r_state  <= w_stateNext;
                r_repCnt <= w_repCntNext;
                r_pulse  <= w_pulseNext;
            end
        end

        assign key_level[i] = r_level;
        assign key_pulse[i] = r_pulse;
    end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// tb_key_repeat_ctrl: scoreboard bench for key_repeat_ctrl with small timing parameters.
// A behavioural model derives debounced levels from a sliding window of the
// synchronised pins and pulse times from arithmetic on time-since-press.
// Honours KEY_REPEAT_ACCEL_EN the same way the design does.

module tb_key_repeat_ctrl;

    localparam int         NK   = 4;
    localparam int         DB   = 4;
    localparam int         RD   = 20;
    localparam int         RP   = 6;
    localparam logic [3:0] MASK = 4'b1110;

    typedef struct {
        int         edgeNo;
        logic [3:0] vec;
    } expT;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] key_level;
    logic [3:0] key_pulse;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] pinHist[$];
    logic [3:0] sHist[$];
    logic [3:0] mLevel = 4'h0;
    int         riseEdge[NK];
    expT        expQ[$];

    key_repeat_ctrl #(
        .NUM_KEYS            (NK),
        .DEBOUNCE_CYCLES     (DB),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_PERIOD_CYCLES(RP),
        .REPEAT_MASK         (MASK)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .key_n    (key_n),
        .key_level(key_level),
        .key_pulse(key_pulse)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // True when n cycles after the press pulse an auto-repeat pulse is due
    function automatic bit isRepeat(input int n);
        int m;
        if (n < RD) return 1'b0;
        m = n - RD;
`ifdef KEY_REPEAT_ACCEL_EN
        if (m > 7 * RP) return ((m - 7 * RP) % (RP / 2)) == 0;
`endif
        return (m % RP) == 0;
    endfunction

    // One comparison with bookkeeping
    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Drive a pin pattern (right after a falling edge) and hold it for a number of cycles
    task automatic applyStimulus(input logic [3:0] pins, input int cycles);
        key_n = pins;
        repeat (cycles) @(negedge clk);
    endtask

    // Reference model: advance one edge and queue any expected pulse
    always @(posedge clk) begin
        logic [3:0] s;
        logic [3:0] newLevel;
        logic [3:0] vec;
        bit         allDiff;
        cyc++;
        if (reset) begin
            pinHist = '{4'hF, 4'hF};
            sHist.delete();
            mLevel = 4'h0;
        end else begin
            s = ~pinHist.pop_front();
            pinHist.push_back(key_n);
            sHist.push_back(s);
            if (sHist.size() > DB) void'(sHist.pop_front());
            newLevel = mLevel;
            vec = 4'h0;
            for (int k = 0; k < NK; k++) begin
                allDiff = (sHist.size() == DB);
                for (int j = 0; j < sHist.size(); j++) begin
                    if (sHist[j][k] == mLevel[k]) allDiff = 1'b0;
                end
                if (allDiff) newLevel[k] = ~mLevel[k];
                if (newLevel[k] && !mLevel[k]) begin
                    riseEdge[k] = cyc;
                    vec[k] = 1'b1;
                end else if (newLevel[k] && mLevel[k] && MASK[k] && isRepeat(cyc - riseEdge[k])) begin
                    vec[k] = 1'b1;
                end
            end
            mLevel = newLevel;
            if (vec != 4'h0) expQ.push_back('{cyc, vec});
        end
    end

    // Monitor: compare level every cycle and match presented pulses against the scoreboard
    always @(negedge clk) begin
        expT e;
        checkOutput("key_level", key_level, mLevel);
        if (key_pulse !== 4'h0) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pulse", key_pulse, 4'h0);
            end else begin
                e = expQ.pop_front();
                checks++;
                if ((e.edgeNo != cyc) || (e.vec !== key_pulse)) begin
                    failures++;
                    $display("[TB] FAIL pulse: got %b at edge %0d expected %b at edge %0d",
                             key_pulse, cyc, e.vec, e.edgeNo);
                end
            end
        end else if ((expQ.size() > 0) && (expQ[0].edgeNo <= cyc)) begin
            e = expQ.pop_front();
            checkOutput("missing_pulse", key_pulse, e.vec);
        end
    end

    initial begin
        reset = 1'b1;
        key_n = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        $display("[TB] reset released, idle keys");
        applyStimulus(4'hF, 50);

        $display("[TB] short press on key 1");
        applyStimulus(4'b1101, 12);
        applyStimulus(4'hF, 30);

        $display("[TB] bouncing key 2 then stable press");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1011, 2);
            applyStimulus(4'hF, 2);
        end
        applyStimulus(4'b1011, 40);
        applyStimulus(4'hF, 20);

        $display("[TB] long hold on key 3");
        applyStimulus(4'b0111, 80);
        applyStimulus(4'hF, 20);

        $display("[TB] long hold on masked key 0");
        applyStimulus(4'b1110, 80);
        applyStimulus(4'hF, 20);

        $display("[TB] keys 0 and 3 together with reset mid-hold");
        applyStimulus(4'b0110, 15);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_level", key_level, 4'h0);
        checkOutput("async_reset_pulse", key_pulse, 4'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b0110, 30);
        applyStimulus(4'hF, 20);

        $display("[TB] random key activity");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'($urandom), $urandom_range(1, 30));
        end
        applyStimulus(4'hF, 40);

        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d pulses still expected, required 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
